// File: rtl/pipe_arb_ctrl.sv
// Two-requester round-robin front end for a DEPTH-stage bubble-collapsing pipeline.
// Define PIPE_ARB_STATS_EN to add saturating per-source accepted-beat counters (a_cnt, b_cnt).
module pipe_arb_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         a_valid,
    input  logic [WIDTH-1:0]             a_data,
    output logic                         a_ready,
    input  logic                         b_valid,
    input  logic [WIDTH-1:0]             b_data,
    output logic                         b_ready,
    input  logic                         flush,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_src,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   occ
`ifdef PIPE_ARB_STATS_EN
    ,
    output logic [15:0]                  a_cnt,
    output logic [15:0]                  b_cnt
`endif
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
        $error("pipe_arb_ctrl: DEPTH must be in 1..16");
    end

    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [DEPTH-1:0] src_q;
    logic [DEPTH-1:0] src_in;
    logic [DEPTH-1:0] en;
    logic [WIDTH-1:0] data_q  [DEPTH];
    logic [WIDTH-1:0] data_in [DEPTH];
    logic [OCC_W-1:0] occ_d;

    // last_grant: 0 = A won the most recent accepted beat, 1 = B.
    logic last_grant;
    logic grant_a;
    logic grant_b;
    logic accept;
    logic accept_a;
    logic accept_b;

    // A stage may load when it is empty or everything ahead of it moves.
    always_comb begin
        logic chain;
        en    = '0;
        chain = !v_q[DEPTH-1] || out_ready;
        en[DEPTH-1] = chain;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            chain = !v_q[i] || chain;
            en[i] = chain;
        end
    end

    // Grant looks only at the valids and the pointer, never at ready.
    always_comb begin
        grant_a = a_valid && (!b_valid || last_grant);
        grant_b = b_valid && (!a_valid || !last_grant);
    end

    assign a_ready  = en[0] && grant_a && !flush;
    assign b_ready  = en[0] && grant_b && !flush;
    assign accept_a = a_valid && a_ready;
    assign accept_b = b_valid && b_ready;
    assign accept   = accept_a || accept_b;

    always_comb begin
        data_in[0] = grant_b ? b_data : a_data;
        src_in[0]  = grant_b;
        for (int i = 1; i < DEPTH; i++) begin
            data_in[i] = data_q[i-1];
            src_in[i]  = src_q[i-1];
        end
    end

    always_comb begin
        v_d = v_q;
        if (flush) begin
            v_d = '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (en[i]) begin
                    v_d[i] = (i == 0) ? accept : v_q[(i == 0) ? 0 : i - 1];
                end
            end
        end
    end

    always_comb begin
        int sum;
        sum = 0;
        for (int i = 0; i < DEPTH; i++) begin
            sum = sum + int'(v_d[i]);
        end
        occ_d = OCC_W'(sum);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q        <= '0;
            src_q      <= '0;
            occ        <= '0;
            last_grant <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            v_q <= v_d;
            occ <= occ_d;
            if (accept) begin
                last_grant <= accept_b;
            end
            // Data of a stage being cleared by flush may load freely; its valid is 0.
            for (int i = 0; i < DEPTH; i++) begin
                if (en[i]) begin
                    data_q[i] <= data_in[i];
                    src_q[i]  <= src_in[i];
                end
            end
        end
    end

    assign out_valid = v_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign out_src   = src_q[DEPTH-1];

`ifdef PIPE_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_cnt <= '0;
            b_cnt <= '0;
        end else if (flush) begin
            a_cnt <= '0;
            b_cnt <= '0;
        end else begin
            if (accept_a && a_cnt != 16'hFFFF) begin
                a_cnt <= a_cnt + 16'd1;
            end
            if (accept_b && b_cnt != 16'hFFFF) begin
                b_cnt <= b_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_arb_ctrl.sv
// Directed bench for pipe_arb_ctrl: a beat-list model checked every negedge plus literal checkpoints.
module tb_pipe_arb_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;
    localparam int OCC_W = $clog2(DEPTH + 1);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             a_valid = 1'b0;
    logic [WIDTH-1:0] a_data = '0;
    logic             a_ready;
    logic             b_valid = 1'b0;
    logic [WIDTH-1:0] b_data = '0;
    logic             b_ready;
    logic             flush = 1'b0;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_src;
    logic             out_ready = 1'b0;
    logic [OCC_W-1:0] occ;
`ifdef PIPE_ARB_STATS_EN
    logic [15:0]      a_cnt;
    logic [15:0]      b_cnt;
`endif

    pipe_arb_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .occ       (occ)
`ifdef PIPE_ARB_STATS_EN
        ,
        .a_cnt     (a_cnt),
        .b_cnt     (b_cnt)
`endif
    );

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // Beats in flight, oldest first; pos is the stage each one occupies.
    typedef struct {
        logic [WIDTH-1:0] d;
        logic             s;
        int               pos;
    } beat_t;

    beat_t      mq[$];
    logic       m_lg = 1'b1;
    logic [15:0] m_acnt = '0;
    logic [15:0] m_bcnt = '0;
    logic       e_valid, e_free, ga, gb, e_ar, e_br;
    int         lim, nx;
    beat_t      bt;

    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_lg   = 1'b1;
            m_acnt = '0;
            m_bcnt = '0;
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_occ", 32'(occ), 32'd0);
        end else begin
            e_valid = (mq.size() > 0) && (mq[0].pos == DEPTH - 1);
            check("m_out_valid", 32'(out_valid), 32'(e_valid));
            check("m_occ", 32'(occ), 32'(mq.size()));
            if (e_valid) begin
                check("m_out_data", 32'(out_data), 32'(mq[0].d));
                check("m_out_src", 32'(out_src), 32'(mq[0].s));
            end
`ifdef PIPE_ARB_STATS_EN
            check("m_a_cnt", 32'(a_cnt), 32'(m_acnt));
            check("m_b_cnt", 32'(b_cnt), 32'(m_bcnt));
`endif
            // Every beat moves one stage forward unless blocked by the beat ahead.
            if (e_valid && out_ready) void'(mq.pop_front());
            lim = DEPTH;
            for (int k = 0; k < mq.size(); k++) begin
                bt = mq[k];
                nx = bt.pos + 1;
                if (nx > lim - 1) nx = lim - 1;
                bt.pos = nx;
                mq[k] = bt;
                lim = nx;
            end
            e_free = (mq.size() == 0) || (mq[mq.size()-1].pos > 0);
            ga   = a_valid && (!b_valid || m_lg);
            gb   = b_valid && (!a_valid || !m_lg);
            e_ar = e_free && ga && !flush;
            e_br = e_free && gb && !flush;
            check("m_a_ready", 32'(a_ready), 32'(e_ar));
            check("m_b_ready", 32'(b_ready), 32'(e_br));
            if (flush) begin
                mq.delete();
                m_acnt = '0;
                m_bcnt = '0;
            end else if (e_ar || e_br) begin
                bt.d   = gb ? b_data : a_data;
                bt.s   = gb;
                bt.pos = 0;
                mq.push_back(bt);
                m_lg = gb;
                if (e_ar && m_acnt != 16'hFFFF) m_acnt = m_acnt + 16'd1;
                if (e_br && m_bcnt != 16'hFFFF) m_bcnt = m_bcnt + 16'd1;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        a_valid = 1'b0;
        b_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset mid-stream with a full pipeline.
        out_ready = 1'b0;
        a_valid   = 1'b1;
        a_data    = 8'h5A;
        for (int i = 0; i < 4; i++) tick();
        check("pre_rst_occ", 32'(occ), 32'd3);
        #1 rst_n = 1'b0;
        #1;
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_occ", 32'(occ), 32'd0);
        check("async_out_data", 32'(out_data), 32'h00);
        tick();
        rst_n = 1'b1;

        // Contention right after reset: A first, then alternate.
        a_valid = 1'b1; a_data = 8'hA1;
        b_valid = 1'b1; b_data = 8'hB1;
        out_ready = 1'b1;
        #1;
        check("first_grant_a", 32'(a_ready), 32'd1);
        check("first_grant_b", 32'(b_ready), 32'd0);
        tick(); tick(); tick();
        check("rr_src0", 32'(out_src), 32'd0);
        tick();
        check("rr_src1", 32'(out_src), 32'd1);
        tick();
        check("rr_src2", 32'(out_src), 32'd0);
        tick();
        check("rr_src3", 32'(out_src), 32'd1);
        idle(5);

        // Single source, three consecutive beats.
        a_valid = 1'b1; a_data = 8'h11;
        #1 check("ss_a_ready0", 32'(a_ready), 32'd1);
        tick();
        a_data = 8'h22;
        check("ss_a_ready1", 32'(a_ready), 32'd1);
        tick();
        a_data = 8'h33;
        check("ss_a_ready2", 32'(a_ready), 32'd1);
        tick();
        a_valid = 1'b0;
        check("ss_out0", 32'(out_data), 32'h11);
        check("ss_src0", 32'(out_src), 32'd0);
        tick();
        check("ss_out1", 32'(out_data), 32'h22);
        tick();
        check("ss_out2", 32'(out_data), 32'h33);
        idle(4);

        // Backpressure with a gap: bubbles collapse.
        out_ready = 1'b0;
        a_valid = 1'b1; a_data = 8'hAA;
        tick();
        a_valid = 1'b0;
        tick();
        a_valid = 1'b1; a_data = 8'hBB;
        tick();
        a_valid = 1'b0;
        tick();
        check("bp_occ2", 32'(occ), 32'd2);
        a_valid = 1'b1; a_data = 8'hCC;
        tick();
        check("bp_occ3", 32'(occ), 32'd3);
        a_data = 8'hDD;
        #1;
        check("bp_full_a_ready", 32'(a_ready), 32'd0);
        check("bp_hold_data", 32'(out_data), 32'hAA);
        tick();
        check("bp_stable_data", 32'(out_data), 32'hAA);
        a_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_drain1", 32'(out_data), 32'hBB);
        tick();
        check("bp_drain2", 32'(out_data), 32'hCC);
        idle(4);

        // Flush a full pipeline last filled from B; pointer must survive.
        out_ready = 1'b0;
        b_valid = 1'b1; b_data = 8'h77;
        for (int i = 0; i < 4; i++) tick();
        b_valid = 1'b0;
        check("fl_pre_occ", 32'(occ), 32'd3);
        out_ready = 1'b1;
        a_valid = 1'b1; a_data = 8'hEE;
        flush = 1'b1;
        #1;
        check("fl_no_accept", 32'(a_ready), 32'd0);
        tick();
        flush = 1'b0;
        a_valid = 1'b0;
        check("fl_occ", 32'(occ), 32'd0);
        check("fl_out_valid", 32'(out_valid), 32'd0);
        a_valid = 1'b1; b_valid = 1'b1;
        #1;
        check("fl_lg_a", 32'(a_ready), 32'd1);
        check("fl_lg_b", 32'(b_ready), 32'd0);
        idle(5);

`ifdef PIPE_ARB_STATS_EN
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("st_cnt_clear", 32'({a_cnt, b_cnt}), 32'd0);
        a_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        a_valid = 1'b0;
        b_valid = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        b_valid = 1'b0;
        check("st_a_cnt", 32'(a_cnt), 32'd5);
        check("st_b_cnt", 32'(b_cnt), 32'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("st_a_flush", 32'(a_cnt), 32'd0);
        check("st_b_flush", 32'(b_cnt), 32'd0);
        idle(4);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
